// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - parametrised snake body engine with sequential self-collision scan
// Optional edge wrap-around is compiled in when SNAKE_WRAP_EN is defined.
module snake_engine #(
  parameter int COORD_W  = 4,
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic               dir_valid,
  input  logic [1:0]         dir_in,
  input  logic [COORD_W-1:0] food_x,
  input  logic [COORD_W-1:0] food_y,
  input  logic [LEN_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               rd_valid,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [LEN_W-1:0]   snake_len,
  output logic [LEN_W-1:0]   score,
  output logic               busy,
  output logic               moved,
  output logic               eaten,
  output logic               tick_miss,
  output logic               game_over,
  output logic               win
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_CALC, S_SCAN, S_COMMIT, S_OVER, S_WIN} state_t;

  localparam logic [1:0] DIR_UP = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_RIGHT = 2'b11;
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] Y_MID  = COORD_W'(GRID_H / 2);
  localparam logic [LEN_W-1:0]   L_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]   L_TWO  = LEN_W'(2);
  localparam logic [LEN_W-1:0]   L_INIT = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0]   L_MAX  = LEN_W'(MAX_LEN);
`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  state_t             state;
  logic [COORD_W-1:0] seg_x [MAX_LEN];
  logic [COORD_W-1:0] seg_y [MAX_LEN];
  logic [1:0]         cur_dir, pending_dir;
  logic [COORD_W-1:0] nxt_x, nxt_y, step_x, step_y;
  logic               grow, edge_hit, dir_ok, rd_in_range;
  logic [LEN_W-1:0]   scan_j, scan_k;

  function automatic logic [COORD_W-1:0] init_x(input int i);
    return (i < INIT_LEN) ? COORD_W'(GRID_W / 2 - i) : '0;
  endfunction

  // A reversal request (dir ^ 1 flips up/down and left/right) is discarded.
  assign dir_ok      = dir_valid && (dir_in != (cur_dir ^ 2'b01));
  assign head_x      = seg_x[0];
  assign head_y      = seg_y[0];
  assign rd_in_range = rd_idx < L_MAX;
  assign rd_x        = rd_in_range ? seg_x[rd_idx[IDX_W-1:0]] : '0;
  assign rd_y        = rd_in_range ? seg_y[rd_idx[IDX_W-1:0]] : '0;
  assign rd_valid    = rd_idx < snake_len;
  assign busy        = (state == S_CALC) || (state == S_SCAN) || (state == S_COMMIT);
  assign game_over   = (state == S_OVER);
  assign win         = (state == S_WIN);

  // Next head cell; edge_hit flags a crossing, step_* already holds the wrapped cell.
  always_comb begin
    step_x   = seg_x[0];
    step_y   = seg_y[0];
    edge_hit = 1'b0;
    case (pending_dir)
      DIR_UP:    if (seg_y[0] == '0)    begin edge_hit = 1'b1; step_y = Y_LAST; end
                 else step_y = seg_y[0] - C_ONE;
      DIR_DOWN:  if (seg_y[0] == Y_LAST) begin edge_hit = 1'b1; step_y = '0; end
                 else step_y = seg_y[0] + C_ONE;
      DIR_LEFT:  if (seg_x[0] == '0)    begin edge_hit = 1'b1; step_x = X_LAST; end
                 else step_x = seg_x[0] - C_ONE;
      DIR_RIGHT: if (seg_x[0] == X_LAST) begin edge_hit = 1'b1; step_x = '0; end
                 else step_x = seg_x[0] + C_ONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= init_x(i);
        seg_y[i] <= Y_MID;
      end
      cur_dir     <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      snake_len   <= L_INIT;
      score       <= '0;
      moved       <= 1'b0;
      eaten       <= 1'b0;
      tick_miss   <= 1'b0;
      nxt_x       <= '0;
      nxt_y       <= '0;
      grow        <= 1'b0;
      scan_j      <= '0;
      scan_k      <= '0;
    end else begin
      moved     <= 1'b0;
      eaten     <= 1'b0;
      tick_miss <= tick && busy;
      if (dir_ok) pending_dir <= dir_in;
      case (state)
        S_IDLE, S_OVER, S_WIN: if (start) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= init_x(i);
            seg_y[i] <= Y_MID;
          end
          cur_dir     <= DIR_RIGHT;
          pending_dir <= DIR_RIGHT;
          snake_len   <= L_INIT;
          score       <= '0;
          state       <= S_RUN;
        end
        S_RUN: if (tick) state <= S_CALC;
        S_CALC: begin
          cur_dir <= pending_dir;
          nxt_x   <= step_x;
          nxt_y   <= step_y;
          grow    <= (step_x == food_x) && (step_y == food_y);
          // Without growth the tail cell is vacated, so it is left out of the scan.
          scan_k  <= ((step_x == food_x) && (step_y == food_y)) ? snake_len - L_ONE
                                                                 : snake_len - L_TWO;
          scan_j  <= '0;
          state   <= (edge_hit && !WRAP) ? S_OVER : S_SCAN;
        end
        S_SCAN: begin
          if ((nxt_x == seg_x[scan_j[IDX_W-1:0]]) && (nxt_y == seg_y[scan_j[IDX_W-1:0]]))
            state <= S_OVER;
          else if (scan_j == scan_k)
            state <= S_COMMIT;
          else
            scan_j <= scan_j + L_ONE;
        end
        S_COMMIT: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nxt_x;
          seg_y[0] <= nxt_y;
          moved    <= 1'b1;
          if (grow) begin
            snake_len <= snake_len + L_ONE;
            score     <= score + L_ONE;
            eaten     <= 1'b1;
          end
          state <= (grow && (snake_len + L_ONE == L_MAX)) ? S_WIN : S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - directed self-checking bench for snake_engine
module tb_snake_engine;

  logic       clk = 1'b0;
  logic       rst, start, tick, dir_valid;
  logic [1:0] dir_in;
  logic [3:0] food_x, food_y, rd_x, rd_y, head_x, head_y;
  logic [5:0] rd_idx, snake_len, score;
  logic       rd_valid, busy, moved, eaten, tick_miss, game_over, win;

  logic       w_start, w_tick, w_dir_valid;
  logic [1:0] w_dir_in;
  logic [3:0] w_food_x, w_food_y, w_rd_x, w_rd_y, w_head_x, w_head_y;
  logic [2:0] w_rd_idx, w_len, w_score;
  logic       w_rd_valid, w_busy, w_moved, w_eaten, w_tick_miss, w_game_over, w_win;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snake_engine dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .dir_valid(dir_valid), .dir_in(dir_in),
    .food_x(food_x), .food_y(food_y), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .head_x(head_x), .head_y(head_y), .snake_len(snake_len),
    .score(score), .busy(busy), .moved(moved), .eaten(eaten), .tick_miss(tick_miss),
    .game_over(game_over), .win(win)
  );

  snake_engine #(.MAX_LEN(4)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .tick(w_tick), .dir_valid(w_dir_valid),
    .dir_in(w_dir_in), .food_x(w_food_x), .food_y(w_food_y), .rd_idx(w_rd_idx),
    .rd_x(w_rd_x), .rd_y(w_rd_y), .rd_valid(w_rd_valid), .head_x(w_head_x),
    .head_y(w_head_y), .snake_len(w_len), .score(w_score), .busy(w_busy), .moved(w_moved),
    .eaten(w_eaten), .tick_miss(w_tick_miss), .game_over(w_game_over), .win(w_win)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic seg_is(input string tag, input int idx, input int ex, input int ey);
    rd_idx = 6'(idx);
    #1;
    check({tag, "_x"}, 32'(rd_x), 32'(ex));
    check({tag, "_y"}, 32'(rd_y), 32'(ey));
  endtask

  task automatic head_is(input string tag, input int ex, input int ey);
    check({tag, "_hx"}, 32'(head_x), 32'(ex));
    check({tag, "_hy"}, 32'(head_y), 32'(ey));
  endtask

  task automatic do_tick_dir(input logic dv, input logic [1:0] d);
    @(negedge clk);
    tick = 1'b1; dir_valid = dv; dir_in = d;
    @(negedge clk);
    tick = 1'b0; dir_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 60 && !(moved || game_over); c++) @(negedge clk);
    if (!(moved || game_over)) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic move(input string tag, input logic dv, input logic [1:0] d);
    do_tick_dir(dv, d);
    wait_done(tag);
    check({tag, "_moved"}, 32'(moved), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pulse_start();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; dir_valid = 1'b0; dir_in = 2'b11;
    food_x = 4'd15; food_y = 4'd15; rd_idx = '0;
    w_start = 1'b0; w_tick = 1'b0; w_dir_valid = 1'b0; w_dir_in = 2'b11;
    w_food_x = 4'd9; w_food_y = 4'd8; w_rd_idx = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_len", 32'(snake_len), 32'd3);
    head_is("rst", 8, 8);
    seg_is("rst_seg2", 2, 6, 8);
    check("rst_rdvalid2", 32'(rd_valid), 32'd1);
    rd_idx = 6'd3; #1;
    check("rst_rdvalid3", 32'(rd_valid), 32'd0);
    check("rst_pulses", {29'd0, moved, eaten, tick_miss}, 32'd0);
    check("rst_over_win", {30'd0, game_over, win}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    pulse_start();

    // plain move and latency (k = 1)
    do_tick_dir(1'b0, 2'b00);
    check("calc_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check("lat_early", 32'(moved), 32'd0);
    @(negedge clk);
    check("lat_moved", 32'(moved), 32'd1);
    check("lat_eaten", 32'(eaten), 32'd0);
    head_is("mv1", 9, 8);
    seg_is("mv1_seg2", 2, 7, 8);
    check("mv1_score", 32'(score), 32'd0);
    @(negedge clk);
    check("moved_one_cycle", 32'(moved), 32'd0);

    // growth: eaten coincides with moved
    restart();
    food_x = 4'd9; food_y = 4'd8;
    move("eat1", 1'b0, 2'b00);
    check("eat1_eaten", 32'(eaten), 32'd1);
    check("eat1_len", 32'(snake_len), 32'd4);
    check("eat1_score", 32'(score), 32'd1);
    head_is("eat1", 9, 8);
    seg_is("eat1_tail", 3, 6, 8);
    food_x = 4'd10;
    move("eat2", 1'b0, 2'b00);
    check("eat2_len", 32'(snake_len), 32'd5);
    food_x = 4'd15; food_y = 4'd15;

    // reversal rejected, then turns (up applied in the tick cycle)
    @(negedge clk); dir_valid = 1'b1; dir_in = 2'b10;
    @(negedge clk); dir_valid = 1'b0;
    move("rev", 1'b0, 2'b00);
    head_is("rev", 11, 8);
    move("up", 1'b1, 2'b00);
    head_is("up", 11, 7);
    move("left", 1'b1, 2'b10);
    head_is("left", 10, 7);
    check("left_eaten", 32'(eaten), 32'd0);

    // U-turn down onto body cell (10,8) at index 3, second tick during SCAN
    do_tick_dir(1'b1, 2'b01);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("tick_miss", 32'(tick_miss), 32'd1);
    @(negedge clk);
    check("tick_miss_clr", 32'(tick_miss), 32'd0);
    wait_done("self");
    check("self_over", 32'(game_over), 32'd1);
    check("self_moved", 32'(moved), 32'd0);
    head_is("self", 10, 7);
    seg_is("self_seg3", 3, 10, 8);
    check("self_len", 32'(snake_len), 32'd5);
    check("self_score", 32'(score), 32'd2);

    // start from OVER reinitialises
    pulse_start();
    check("restart_over", 32'(game_over), 32'd0);
    check("restart_len", 32'(snake_len), 32'd3);
    check("restart_score", 32'(score), 32'd0);
    head_is("restart", 8, 8);

    // right edge
    for (int i = 0; i < 7; i++) move("to_edge", 1'b0, 2'b00);
    head_is("edge", 15, 8);
    do_tick_dir(1'b0, 2'b00);
`ifdef SNAKE_WRAP_EN
    wait_done("wrap");
    check("wrap_moved", 32'(moved), 32'd1);
    head_is("wrap", 0, 8);
    check("wrap_over", 32'(game_over), 32'd0);
`else
    @(negedge clk);
    check("wall_over", 32'(game_over), 32'd1);
    check("wall_moved", 32'(moved), 32'd0);
    head_is("wall", 15, 8);
    seg_is("wall_seg2", 2, 13, 8);
    check("wall_len", 32'(snake_len), 32'd3);
`endif

    // win at MAX_LEN = 4 after one food
    @(negedge clk); w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    check("w_pre_win", 32'(w_win), 32'd0);
    @(negedge clk); w_tick = 1'b1;
    @(negedge clk); w_tick = 1'b0;
    for (int c = 0; c < 60 && !w_moved; c++) @(negedge clk);
    check("w_moved", 32'(w_moved), 32'd1);
    check("w_eaten", 32'(w_eaten), 32'd1);
    check("w_len", 32'(w_len), 32'd4);
    check("w_score", 32'(w_score), 32'd1);
    @(negedge clk);
    check("w_win", 32'(w_win), 32'd1);
    check("w_over", 32'(w_game_over), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
